// File: rtl/mux_sel_sequencer.sv
// Serializes a 4-bit word onto a 1-bit 4:1 mux by stepping its select line,
// holding each index HOLD_CYCLES cycles and flagging strobe/first/last.
module mux_sel_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned MSB_FIRST   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_data,
    input  logic       stall,
    output logic       I0,
    output logic       I1,
    output logic       I2,
    output logic       I3,
    output logic [1:0] sel,
    output logic       busy,
    output logic       bit_strobe,
    output logic       first,
    output logic       last
);

    localparam int unsigned     CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST_CNT  = CW'(HOLD_CYCLES - 1);
    localparam logic [1:0]      START_IDX = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
    localparam logic [1:0]      END_IDX   = (MSB_FIRST != 0) ? 2'd0 : 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [3:0]    r_word, w_word_nxt;
    logic          w_hold_done;
    logic          w_strobe;
    logic          w_ready;
    logic          w_accept;

    always_comb begin
        w_hold_done = (r_cnt == LAST_CNT);
        // Strobe is gated by rst_n so an aborted word emits nothing more.
        w_strobe    = rst_n && (r_state == ST_SHIFT) && !stall && w_hold_done;
        w_ready     = rst_n && ((r_state == ST_IDLE) || (w_strobe && (r_sel == END_IDX)));
        w_accept    = load_valid && w_ready;

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_word_nxt  = r_word;

        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_word_nxt  = load_data;
            w_sel_nxt   = START_IDX;
            w_cnt_nxt   = '0;
        end else if ((r_state == ST_SHIFT) && !stall) begin
            if (w_hold_done) begin
                w_cnt_nxt = '0;
                if (r_sel == END_IDX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_sel_nxt = (MSB_FIRST != 0) ? (r_sel - 2'd1) : (r_sel + 2'd1);
                end
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_word  <= w_word_nxt;
        end
    end

    assign load_ready = w_ready;
    assign bit_strobe = w_strobe;
    assign first      = w_strobe && (r_sel == START_IDX);
    assign last       = w_strobe && (r_sel == END_IDX);
    assign busy       = (r_state == ST_SHIFT);
    assign sel        = r_sel;
    assign I0         = r_word[0];
    assign I1         = r_word[1];
    assign I2         = r_word[2];
    assign I3         = r_word[3];

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Drives three sequencer configurations with shared stimulus and checks each
// against a word-position reference model every cycle.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [3:0] load_data;
    logic       stall;

    logic       rdy [3];
    logic       bsy [3];
    logic       stb [3];
    logic       fst [3];
    logic       lst [3];
    logic [1:0] sel_o [3];
    logic [3:0] iw [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int         hcfg [3] = '{1, 3, 2};
    int         mcfg [3] = '{0, 1, 0};
    int         m_pos  [3];
    bit         m_busy [3];
    logic [3:0] m_word [3];
    logic [1:0] m_isel [3];
    int         nstrobe [3];

    always #5 clk = ~clk;

    mux_sel_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(0)) u_h1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy[0]),
        .load_data(load_data), .stall(stall),
        .I0(iw[0][0]), .I1(iw[0][1]), .I2(iw[0][2]), .I3(iw[0][3]),
        .sel(sel_o[0]), .busy(bsy[0]), .bit_strobe(stb[0]), .first(fst[0]), .last(lst[0])
    );

    mux_sel_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1)) u_h3 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy[1]),
        .load_data(load_data), .stall(stall),
        .I0(iw[1][0]), .I1(iw[1][1]), .I2(iw[1][2]), .I3(iw[1][3]),
        .sel(sel_o[1]), .busy(bsy[1]), .bit_strobe(stb[1]), .first(fst[1]), .last(lst[1])
    );

    mux_sel_sequencer #(.HOLD_CYCLES(2), .MSB_FIRST(0)) u_h2 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy[2]),
        .load_data(load_data), .stall(stall),
        .I0(iw[2][0]), .I1(iw[2][1]), .I2(iw[2][2]), .I3(iw[2][3]),
        .sel(sel_o[2]), .busy(bsy[2]), .bit_strobe(stb[2]), .first(fst[2]), .last(lst[2])
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, compare, then advance the model.
    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic s);
        @(negedge clk);
        rst_n      = r;
        load_valid = v;
        load_data  = d;
        stall      = s;
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            int          idx;
            logic        e_stb, e_fst, e_lst, e_rdy, acc;
            logic [1:0]  e_sel;
            logic [10:0] exp_v, got_v;
            idx   = m_pos[k] / hcfg[k];
            e_stb = r && m_busy[k] && !s && ((m_pos[k] % hcfg[k]) == hcfg[k] - 1);
            e_fst = e_stb && (idx == 0);
            e_lst = e_stb && (idx == 3);
            e_rdy = r && (!m_busy[k] || e_lst);
            acc   = v && e_rdy;
            if (m_busy[k]) e_sel = (mcfg[k] != 0) ? 2'(3 - idx) : 2'(idx);
            else           e_sel = m_isel[k];
            exp_v = {e_rdy, m_busy[k], e_stb, e_fst, e_lst, e_sel, m_word[k]};
            got_v = {rdy[k], bsy[k], stb[k], fst[k], lst[k], sel_o[k], iw[k]};
            chk_eq($sformatf("cyc%0d_u%0d{rdy,busy,stb,fst,lst,sel,I}", cyc, k), 32'(got_v), 32'(exp_v));
            if (stb[k] === 1'b1) nstrobe[k]++;

            if (!r) begin
                m_busy[k] = 1'b0;
                m_pos[k]  = 0;
                m_word[k] = 4'h0;
                m_isel[k] = 2'd0;
            end else if (acc) begin
                m_busy[k] = 1'b1;
                m_pos[k]  = 0;
                m_word[k] = d;
            end else if (m_busy[k] && !s) begin
                m_pos[k]++;
                if (m_pos[k] == 4 * hcfg[k]) begin
                    m_busy[k] = 1'b0;
                    m_isel[k] = (mcfg[k] != 0) ? 2'd0 : 2'd3;
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) nstrobe[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_pos[k] = 0; m_busy[k] = 1'b0; m_word[k] = 4'h0; m_isel[k] = 2'd0; nstrobe[k] = 0;
        end
        rst_n = 1'b0; load_valid = 1'b1; load_data = 4'hF; stall = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with load_valid high, then release.
        step(1'b0, 1'b1, 4'hF, 1'b0);
        step(1'b0, 1'b1, 4'hF, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Single words, each configuration must strobe exactly four times.
        clear_counts();
        step(1'b1, 1'b1, 4'b1010, 1'b0);
        repeat (14) step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) chk_eq($sformatf("word1010_strobes_u%0d", k), 32'(nstrobe[k]), 32'd4);

        clear_counts();
        step(1'b1, 1'b1, 4'b0110, 1'b1);
        repeat (14) step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) chk_eq($sformatf("word0110_strobes_u%0d", k), 32'(nstrobe[k]), 32'd4);

        // Back-to-back words with load_valid held high.
        step(1'b1, 1'b1, 4'hA, 1'b0);
        clear_counts();
        repeat (8) step(1'b1, 1'b1, 4'h5, 1'b0);
        chk_eq("b2b_contiguous_strobes_h1", 32'(nstrobe[0]), 32'd8);
        repeat (30) step(1'b1, 1'b0, 4'h0, 1'b0);

        // Stall mid-index.
        clear_counts();
        step(1'b1, 1'b1, 4'hC, 1'b0);
        repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 4'h0, 1'b1);
        repeat (14) step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) chk_eq($sformatf("stall_strobes_u%0d", k), 32'(nstrobe[k]), 32'd4);

        // Reset mid-word aborts it, then a fresh word.
        step(1'b1, 1'b1, 4'h9, 1'b0);
        repeat (4) step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h3, 1'b0);
        repeat (14) step(1'b1, 1'b0, 4'h0, 1'b0);

        // Randomized traffic.
        repeat (3000) begin
            logic r, v, s;
            logic [3:0] d;
            r = ($urandom_range(0, 99) != 0);
            v = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 4) == 0);
            d = 4'($urandom);
            step(r, v, d, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
